// File: rtl/hub75_blank_ctrl.sv
// HUB75 blanking controller: turns one-hot BCM plane requests into weighted OE windows.
// Optional global dimming when HUB75_BLANK_PWM_EN is defined.
module hub75_blank_ctrl #(
    parameter int unsigned N_PLANES = 8
) (
    input  logic                clk,
    input  logic                rst,
    output logic                hub75_blank,
    input  logic [N_PLANES-1:0] blank_plane,
    input  logic                blank_go,
    output logic                blank_rdy,
    input  logic [7:0]          cfg_bit_len,
    input  logic [7:0]          cfg_guard_len,
    input  logic [7:0]          cfg_brightness
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ON    = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [N_PLANES-1:0] w_q, w_d;
    logic [7:0]          p_q, p_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          g_q, g_d;
    logic                blank_d;
    logic                on_now;

`ifdef HUB75_BLANK_PWM_EN
    logic [7:0] bright_q, bright_d;
    logic [7:0] offset;
`else
    logic unused_bright;
    assign unused_bright = ^cfg_brightness;
`endif

    assign blank_rdy = (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        p_d     = p_q;
        len_d   = len_q;
        g_d     = g_q;
`ifdef HUB75_BLANK_PWM_EN
        bright_d = bright_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (blank_go) begin
                    w_d     = blank_plane;
                    p_d     = cfg_bit_len;
                    len_d   = cfg_bit_len;
                    g_d     = cfg_guard_len;
`ifdef HUB75_BLANK_PWM_EN
                    bright_d = cfg_brightness;
`endif
                    state_d = (blank_plane == '0) ? ST_GUARD : ST_ON;
                end
            end
            ST_ON: begin
                if (p_q == 8'd0) begin
                    if (w_q == N_PLANES'(1)) begin
                        state_d = ST_GUARD;
                        w_d     = '0;
                    end else begin
                        p_d = len_q;
                        w_d = w_q - N_PLANES'(1);
                    end
                end else begin
                    p_d = p_q - 8'd1;
                end
            end
            ST_GUARD: begin
                // A zero guard length still costs one blanked cycle.
                if (g_q <= 8'd1) begin
                    state_d = ST_IDLE;
                    g_d     = 8'd0;
                end else begin
                    g_d = g_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef HUB75_BLANK_PWM_EN
    // Position within the current prescaler period; p counts down from len.
    assign offset = len_q - p_q;
    assign on_now = (state_q == ST_ON) && (offset < bright_q);
`else
    assign on_now = (state_q == ST_ON);
`endif

    assign blank_d = ~on_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            w_q         <= '0;
            p_q         <= 8'd0;
            len_q       <= 8'd0;
            g_q         <= 8'd0;
            hub75_blank <= 1'b1;
`ifdef HUB75_BLANK_PWM_EN
            bright_q    <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            p_q         <= p_d;
            len_q       <= len_d;
            g_q         <= g_d;
            hub75_blank <= blank_d;
`ifdef HUB75_BLANK_PWM_EN
            bright_q    <= bright_d;
`endif
        end
    end

endmodule
